// File: rtl/commit_trace_buffer_if.sv
// ============================================================================
// Module   : commit_trace_buffer_if
// Purpose  : Bundles the commit-stage sample inputs, the pipeline stall
//            back-pressure and the trace-record valid/ready stream.
// Ports    : slave  - the trace buffer (reads cm_*/out_ready, drives stall/out_*)
//            master - the pipeline/consumer side
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface commit_trace_buffer_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 32
);
  // Commit-stage sample
  logic              cm_valid;
  logic [DATA_W-1:0] cm_pc;
  logic              cm_reg_we;
  logic              cm_mem_rd;
  logic              cm_mem_wr;
  logic              cm_halt;
  logic              cm_err;
  logic [REG_W-1:0]  cm_reg_idx;
  logic [DATA_W-1:0] cm_reg_data;
  logic [DATA_W-1:0] cm_mem_addr;
  logic [DATA_W-1:0] cm_mem_data;
  logic              stall;

  // Trace record stream
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_kind;
  logic [CNT_W-1:0]  out_inum;
  logic [CNT_W-1:0]  out_cycle;
  logic [DATA_W-1:0] out_pc;
  logic [REG_W-1:0]  out_reg_idx;
  logic [DATA_W-1:0] out_reg_data;
  logic [DATA_W-1:0] out_mem_addr;
  logic [DATA_W-1:0] out_mem_data;

  modport master (
    output cm_valid, cm_pc, cm_reg_we, cm_mem_rd, cm_mem_wr, cm_halt, cm_err,
           cm_reg_idx, cm_reg_data, cm_mem_addr, cm_mem_data, out_ready,
    input  stall, out_valid, out_kind, out_inum, out_cycle, out_pc,
           out_reg_idx, out_reg_data, out_mem_addr, out_mem_data
  );

  modport slave (
    input  cm_valid, cm_pc, cm_reg_we, cm_mem_rd, cm_mem_wr, cm_halt, cm_err,
           cm_reg_idx, cm_reg_data, cm_mem_addr, cm_mem_data, out_ready,
    output stall, out_valid, out_kind, out_inum, out_cycle, out_pc,
           out_reg_idx, out_reg_data, out_mem_addr, out_mem_data
  );
endinterface

`default_nettype wire

// File: rtl/commit_trace_buffer.sv
// ============================================================================
// Module   : commit_trace_buffer
// Purpose  : Samples MEM/WB commit events, classifies them into typed trace
//            records, buffers them in a DEPTH-entry FIFO and drains them over
//            a valid/ready stream. Tracks instruction/cycle/drop counters and
//            a terminal run-state (halt, instruction limit, error).
// Ports    : clk, rst        - clock, synchronous active-high reset
//            bus (slave)     - commit sample, stall, trace record stream
//            inst_count, cycle_count, drop_count - running counters
//            state           - 0 RUN, 1 DONE_HALT, 2 DONE_LIMIT, 3 ERROR
//            overflow        - sticky, a record was dropped
//            done            - terminal state reached and FIFO drained
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_trace_buffer #(
  parameter int DATA_W        = 16,
  parameter int REG_W         = 3,
  parameter int CNT_W         = 32,
  parameter int DEPTH         = 8,
  parameter int MAX_INST      = 10000,
  parameter int STALL_ON_FULL = 0
) (
  input  wire logic              clk,
  input  wire logic              rst,
  commit_trace_buffer_if.slave   bus,
  output logic [CNT_W-1:0]       inst_count,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [CNT_W-1:0]       drop_count,
  output logic [1:0]             state,
  output logic                   overflow,
  output logic                   done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_INUM = CNT_W'(MAX_INST - 1);

  localparam logic [2:0] K_NOP  = 3'd0;
  localparam logic [2:0] K_REG  = 3'd1;
  localparam logic [2:0] K_LD   = 3'd2;
  localparam logic [2:0] K_STU  = 3'd3;
  localparam logic [2:0] K_ST   = 3'd4;
  localparam logic [2:0] K_HALT = 3'd5;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_LIMIT = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0]        kind;
    logic [CNT_W-1:0]  inum;
    logic [CNT_W-1:0]  cycle;
    logic [DATA_W-1:0] pc;
    logic [REG_W-1:0]  reg_idx;
    logic [DATA_W-1:0] reg_data;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
  } rec_t;

  state_t            r_state, w_next;
  rec_t              r_mem [DEPTH];
  logic [AW:0]       r_wr, r_rd;
  logic [CNT_W-1:0]  r_inst_count, r_cycle_count, r_drop_count;
  logic              r_overflow;

  logic              w_empty, w_full, w_pop;
  logic              w_capture, w_accept, w_drop, w_count;
  rec_t              w_rec, w_head;

  // Extra pointer bit separates full from empty when the index bits match.
  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = !w_empty && bus.out_ready;

  // Classification, capture decision and next run-state
  always_comb begin
    w_rec     = '0;
    w_next    = r_state;
    w_rec.pc  = bus.cm_pc;
    w_rec.inum  = r_inst_count;
    w_rec.cycle = r_cycle_count;

    if (bus.cm_reg_we && bus.cm_mem_wr)      w_rec.kind = K_STU;
    else if (bus.cm_reg_we && bus.cm_mem_rd) w_rec.kind = K_LD;
    else if (bus.cm_reg_we)                  w_rec.kind = K_REG;
    else if (bus.cm_halt)                    w_rec.kind = K_HALT;
    else if (bus.cm_mem_wr)                  w_rec.kind = K_ST;
    else                                     w_rec.kind = K_NOP;

    // Fields a kind does not use stay zero so records compare cleanly.
    if (bus.cm_reg_we) begin
      w_rec.reg_idx  = bus.cm_reg_idx;
      w_rec.reg_data = bus.cm_reg_data;
    end
    if (w_rec.kind == K_LD || w_rec.kind == K_STU || w_rec.kind == K_ST)
      w_rec.mem_addr = bus.cm_mem_addr;
    if (w_rec.kind == K_STU || w_rec.kind == K_ST)
      w_rec.mem_data = bus.cm_mem_data;

    w_capture = (r_state == S_RUN) && bus.cm_valid && !bus.cm_err;
    // A full FIFO still accepts when the head leaves in the same cycle.
    w_accept  = w_capture && (!w_full || w_pop);
    w_drop    = w_capture && !w_accept && (STALL_ON_FULL == 0);
    w_count   = w_accept || w_drop;

    if (r_state == S_RUN) begin
      if (bus.cm_valid && bus.cm_err)
        w_next = S_ERR;
      else if (w_count && w_rec.kind == K_HALT)
        w_next = S_HALT;
      else if (w_count && (MAX_INST != 0) && (r_inst_count == LAST_INUM))
        w_next = S_LIMIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr          <= '0;
      r_rd          <= '0;
      r_inst_count  <= '0;
      r_cycle_count <= '0;
      r_drop_count  <= '0;
      r_overflow    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr[AW-1:0]] <= w_rec;
        r_wr                <= r_wr + (AW+1)'(1);
      end
      if (w_pop)
        r_rd <= r_rd + (AW+1)'(1);
      if (w_count)
        r_inst_count <= r_inst_count + CNT_W'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) r_drop_count <= r_drop_count + CNT_W'(1);
      end
      if (r_state == S_RUN && r_cycle_count != '1)
        r_cycle_count <= r_cycle_count + CNT_W'(1);
    end
  end

  generate
    if (STALL_ON_FULL != 0) begin : g_stall
      assign bus.stall = w_full && !w_pop;
    end else begin : g_nostall
      assign bus.stall = 1'b0;
    end
  endgenerate

  assign w_head           = r_mem[r_rd[AW-1:0]];
  assign bus.out_valid    = !w_empty;
  assign bus.out_kind     = w_head.kind;
  assign bus.out_inum     = w_head.inum;
  assign bus.out_cycle    = w_head.cycle;
  assign bus.out_pc       = w_head.pc;
  assign bus.out_reg_idx  = w_head.reg_idx;
  assign bus.out_reg_data = w_head.reg_data;
  assign bus.out_mem_addr = w_head.mem_addr;
  assign bus.out_mem_data = w_head.mem_data;

  assign inst_count  = r_inst_count;
  assign cycle_count = r_cycle_count;
  assign drop_count  = r_drop_count;
  assign state       = r_state;
  assign overflow    = r_overflow;
  assign done        = (r_state != S_RUN) && w_empty;

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
// ============================================================================
// Module   : tb_commit_trace_buffer
// Purpose  : Self-checking bench for commit_trace_buffer. Three instances:
//            0 = drop on full, 1 = stall on full, 2 = MAX_INST of 5.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_trace_buffer;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [31:0] cyc;
    logic [15:0] pc;
    logic [2:0]  idx;
    logic [15:0] rdata;
    logic [15:0] maddr;
    logic [15:0] mdata;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  rec_t q[$];
  rec_t exp_r;
  int   tb_cyc;

  logic [1:0]  sel = 2'd0;
  logic        c_valid = 1'b0;
  logic        c_we = 1'b0, c_rd = 1'b0, c_wr = 1'b0, c_halt = 1'b0, c_err = 1'b0;
  logic [15:0] c_pc = '0, c_rdata = '0, c_maddr = '0, c_mdata = '0;
  logic [2:0]  c_idx = '0;
  logic [2:0]  rdy = '0;

  rec_t        act [3];
  logic [2:0]  vld, stl, ovf_c, done_c;
  logic [31:0] inst_c [3];
  logic [31:0] cyc_c [3];
  logic [31:0] drop_c [3];
  logic [1:0]  state_c [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    commit_trace_buffer_if #(.DATA_W(16), .REG_W(3), .CNT_W(32)) bus ();
    assign bus.cm_valid    = c_valid && (sel == 2'(k));
    assign bus.cm_pc       = c_pc;
    assign bus.cm_reg_we   = c_we;
    assign bus.cm_mem_rd   = c_rd;
    assign bus.cm_mem_wr   = c_wr;
    assign bus.cm_halt     = c_halt;
    assign bus.cm_err      = c_err;
    assign bus.cm_reg_idx  = c_idx;
    assign bus.cm_reg_data = c_rdata;
    assign bus.cm_mem_addr = c_maddr;
    assign bus.cm_mem_data = c_mdata;
    assign bus.out_ready   = rdy[k];

    commit_trace_buffer #(
      .DATA_W(16), .REG_W(3), .CNT_W(32), .DEPTH(8),
      .MAX_INST((k == 2) ? 5 : 10000),
      .STALL_ON_FULL((k == 1) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst), .bus(bus),
      .inst_count(inst_c[k]), .cycle_count(cyc_c[k]), .drop_count(drop_c[k]),
      .state(state_c[k]), .overflow(ovf_c[k]), .done(done_c[k])
    );

    assign act[k] = {bus.out_kind, bus.out_inum, bus.out_cycle, bus.out_pc,
                     bus.out_reg_idx, bus.out_reg_data, bus.out_mem_addr, bus.out_mem_data};
    assign vld[k] = bus.out_valid;
    assign stl[k] = bus.stall;
  end

  // Independent cycle reference: edges out of reset since the last reset.
  always @(posedge clk) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
  end

  // Monitor: a record offered with ready high leaves at the next edge.
  always @(negedge clk) begin
    if (!rst && vld[sel] && rdy[sel]) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record got %h exp none", act[sel]);
      end else begin
        exp_r = q.pop_front();
        if (act[sel] !== exp_r) begin
          errors++;
          $display("FAIL record got %h exp %h", act[sel], exp_r);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  // Present one event (flags = {we,rd,wr,halt,err}), hold it through any stall,
  // and queue the hand-specified expected record when push is set.
  task automatic send(input logic [1:0] d, input logic [15:0] pc, input logic [4:0] fl,
                      input logic [2:0] idx, input logic [15:0] rdata, input logic [15:0] maddr,
                      input logic [15:0] mdata, input logic push, input logic [2:0] kind,
                      input int inum);
    rec_t e;
    int   n;
    sel = d; c_valid = 1'b1; c_pc = pc; {c_we, c_rd, c_wr, c_halt, c_err} = fl;
    c_idx = idx; c_rdata = rdata; c_maddr = maddr; c_mdata = mdata;
    n = 0;
    @(negedge clk);
    while (stl[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL stall_timeout got stall exp release");
    end
    if (push) begin
      e = '0;
      e.kind = kind; e.inum = 32'(inum); e.cyc = 32'(tb_cyc); e.pc = pc;
      if (kind == 3'd1 || kind == 3'd2 || kind == 3'd3) begin
        e.idx = idx; e.rdata = rdata;
      end
      if (kind == 3'd2 || kind == 3'd3 || kind == 3'd4) e.maddr = maddr;
      if (kind == 3'd3 || kind == 3'd4) e.mdata = mdata;
      q.push_back(e);
    end
    @(posedge clk);
    #1 c_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d exp 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    c_valid = 1'b0; rdy = '0; rst = 1'b1;
    {c_we, c_rd, c_wr, c_halt, c_err} = '0;
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Reset state of every instance
    do_reset();
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", 32'(vld[k]), 0);
      chk("rst_state", 32'(state_c[k]), 0);
      chk("rst_inst", inst_c[k], 0);
      chk("rst_cycle", cyc_c[k], 0);
      chk("rst_done", 32'(done_c[k]), 0);
      checks++;
      if (act[k] !== '0) begin
        errors++;
        $display("FAIL rst_out got %h exp 0", act[k]);
      end
    end

    // Single REG event; unused mem fields must come out zero
    rdy = 3'b001;
    send(0, 16'h0010, 5'b10000, 3'd3, 16'h1234, 16'hAAAA, 16'h5555, 1'b1, 3'd1, 0);
    chk("one_inst", inst_c[0], 1);
    drain();

    // Classification back to back
    do_reset();
    rdy = 3'b001;
    send(0, 16'h0020, 5'b10100, 3'd1, 16'h1111, 16'h0100, 16'h2222, 1'b1, 3'd3, 0);
    send(0, 16'h0022, 5'b11000, 3'd2, 16'h3333, 16'h0102, 16'h4444, 1'b1, 3'd2, 1);
    send(0, 16'h0024, 5'b00100, 3'd4, 16'h5555, 16'h0104, 16'h6666, 1'b1, 3'd4, 2);
    send(0, 16'h0026, 5'b00000, 3'd5, 16'h7777, 16'h0106, 16'h8888, 1'b1, 3'd0, 3);
    drain();
    chk("class_inst", inst_c[0], 4);

    // Overflow with drop
    do_reset();
    for (int i = 0; i < 10; i++)
      send(0, 16'(256 + 2 * i), 5'b10000, 3'(i), 16'(40960 + i), 16'h0, 16'h0, (i < 8), 3'd1, i);
    chk("drop_count", drop_c[0], 2);
    chk("drop_ovf", 32'(ovf_c[0]), 1);
    chk("drop_inst", inst_c[0], 10);
    chk("drop_stall", 32'(stl[0]), 0);
    rdy = 3'b001;
    drain();
    chk("drop_done", 32'(done_c[0]), 0);

    // Back-pressure instead of drop
    do_reset();
    for (int i = 0; i < 8; i++)
      send(1, 16'(512 + 2 * i), 5'b10000, 3'(i), 16'(45056 + i), 16'h0, 16'h0, 1'b1, 3'd1, i);
    sel = 2'd1; c_valid = 1'b1; c_pc = 16'h0210; {c_we, c_rd, c_wr, c_halt, c_err} = 5'b10000;
    c_idx = 3'd0; c_rdata = 16'hB008;
    @(negedge clk);
    chk("stall_high", 32'(stl[1]), 1);
    chk("stall_inst", inst_c[1], 8);
    @(posedge clk);
    #1 rdy = 3'b010;
    send(1, 16'h0210, 5'b10000, 3'd0, 16'hB008, 16'h0, 16'h0, 1'b1, 3'd1, 8);
    send(1, 16'h0212, 5'b10000, 3'd1, 16'hB009, 16'h0, 16'h0, 1'b1, 3'd1, 9);
    drain();
    chk("stall_drop", drop_c[1], 0);
    chk("stall_inst_end", inst_c[1], 10);
    chk("stall_ovf", 32'(ovf_c[1]), 0);

    // Instruction limit
    do_reset();
    for (int i = 0; i < 5; i++)
      send(2, 16'(768 + 2 * i), 5'b10000, 3'(i), 16'(49152 + i), 16'h0, 16'h0, 1'b1, 3'd1, i);
    chk("limit_state", 32'(state_c[2]), 2);
    send(2, 16'h030A, 5'b10000, 3'd5, 16'hC005, 16'h0, 16'h0, 1'b0, 3'd1, 5);
    send(2, 16'h030C, 5'b10000, 3'd6, 16'hC006, 16'h0, 16'h0, 1'b0, 3'd1, 6);
    chk("limit_inst", inst_c[2], 5);
    chk("limit_done_wait", 32'(done_c[2]), 0);
    rdy = 3'b100;
    drain();
    chk("limit_done", 32'(done_c[2]), 1);
    chk("limit_state_end", 32'(state_c[2]), 2);

    // Halt, then halt+err
    do_reset();
    rdy = 3'b001;
    send(0, 16'h0044, 5'b00010, 3'd6, 16'hBEEF, 16'h0001, 16'h0002, 1'b1, 3'd5, 0);
    chk("halt_state", 32'(state_c[0]), 1);
    drain();
    chk("halt_done", 32'(done_c[0]), 1);
    do_reset();
    rdy = 3'b001;
    send(0, 16'h0046, 5'b00011, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd5, 0);
    chk("err_state", 32'(state_c[0]), 3);
    chk("err_valid", 32'(vld[0]), 0);
    chk("err_inst", inst_c[0], 0);
    chk("err_done", 32'(done_c[0]), 1);

    // Reset with records still buffered
    do_reset();
    for (int i = 0; i < 4; i++)
      send(0, 16'(1024 + 2 * i), 5'b10000, 3'(i), 16'(i), 16'h0, 16'h0, 1'b0, 3'd1, i);
    chk("pre_rst_valid", 32'(vld[0]), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_valid", 32'(vld[0]), 0);
    chk("mid_rst_inst", inst_c[0], 0);
    chk("mid_rst_cycle", cyc_c[0], 0);
    chk("mid_rst_state", 32'(state_c[0]), 0);

    chk("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Synthesizable retirement-trace monitor for the pipelined core. It samples the MEM/WB-stage commit signals once per cycle and classifies each event into a typed trace record. Records are buffered in a parametrised FIFO and drained over a valid/ready stream. The block replaces the per-cycle simulation trace with a hardware equivalent that adds instruction and cycle counters, overflow handling and a run-state machine (halt, instruction limit, error).

## Interface
- DATA_W, 16, PC, register data, memory address and memory data width
- REG_W, 3, register index width
- CNT_W, 32, instruction and cycle counter width
- DEPTH, 8, FIFO entries; power of two, at least 2
- MAX_INST, 10000, record limit; 0 disables the limit
- STALL_ON_FULL, 0, 1 = back-pressure the pipeline, 0 = drop records and count drops
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cm_valid  in  1  commit event present this cycle
- cm_pc  in  DATA_W  PC of the committing instruction
- cm_reg_we, cm_mem_rd, cm_mem_wr, cm_halt, cm_err  in  1 each  commit attributes
- cm_reg_idx  in  REG_W  destination register index
- cm_reg_data  in  DATA_W  register write data
- cm_mem_addr, cm_mem_data  in  DATA_W each  memory address and store data
- stall  out  1  FIFO full with no pop this cycle; forced 0 when STALL_ON_FULL=0
- out_valid  out  1  trace record available
- out_ready  in  1  consumer accepts the record
- out_kind  out  3  0 NOP/branch, 1 REG, 2 LD, 3 STU, 4 ST, 5 HALT
- out_inum, out_cycle  out  CNT_W each  instruction number and cycle at capture
- out_pc, out_reg_data, out_mem_addr, out_mem_data  out  DATA_W each  record payload
- out_reg_idx  out  REG_W  record payload
- inst_count, cycle_count, drop_count  out  CNT_W each  running counters
- state  out  2  0 RUN, 1 DONE_HALT, 2 DONE_LIMIT, 3 ERROR
- overflow  out  1  sticky, set on first dropped record
- done  out  1  state != RUN and FIFO empty

## Operation
- Classification applies this priority: reg_we&mem_wr → STU; reg_we&mem_rd → LD; reg_we → REG; halt → HALT; mem_wr → ST; otherwise NOP.
- Capture fires when state=RUN and cm_valid=1 and cm_err=0.
- Capture is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Accepted capture:
  - Pushes {kind, inum=inst_count, cycle=cycle_count, payload}.
  - Increments inst_count.
  - Payload fields unused by the kind are stored as 0.
- Rejected capture, STALL_ON_FULL=0:
  - drop_count increments, saturating at all-ones.
  - overflow is set.
  - inst_count still increments.
- Rejected capture, STALL_ON_FULL=1:
  - stall is high. The pipeline holds the cm_* inputs; nothing is counted.
- State transitions (from RUN only):
  - cm_valid&cm_err → ERROR. The event is not recorded. err has priority over halt.
  - An accepted or dropped HALT record → DONE_HALT.
  - Otherwise, a capture numbered MAX_INST-1 → DONE_LIMIT.
- Non-RUN states are terminal until rst. No further captures occur; the FIFO keeps draining.
- cycle_count increments every cycle in RUN, saturating; it freezes outside RUN.
- Pop occurs when out_valid&out_ready. FIFO pointers wrap modulo DEPTH; the full/empty distinction uses an extra pointer bit.

## Timing
- Reset values: all outputs 0, state RUN, FIFO empty.
- rst mid-operation flushes the FIFO and clears counters and overflow on the next edge.
- A record captured at edge N is visible on out_* at N+1. out_* are registered directly from the FIFO head.
- out_* hold stable while out_valid=1 and out_ready=0.
- stall is combinational from full and (out_valid&out_ready).
- state and done update at the capture edge; done waits for the last pop.
- Throughput: one record per cycle sustained when out_ready=1.

## Test plan
- Reset, then one event with reg_we=1, idx=3, data=0x1234, pc=0x0010 → next cycle out_valid, kind=1, inum=0, reg_idx=3, data=0x1234; inst_count=1.
- Back-to-back classification: reg_we+mem_wr, reg_we+mem_rd, mem_wr only, no flags → kinds 3, 2, 4, 0 in order, with inum 0..3.
- DEPTH=8, STALL_ON_FULL=0, out_ready=0, 10 events → 8 records buffered, drop_count=2, overflow=1, inst_count=10.
- Same sequence with STALL_ON_FULL=1 → stall rises on the 9th event. Raising out_ready drains in order with no loss; drop_count=0.
- MAX_INST=5, 7 events → state=DONE_LIMIT after the 5th. The 6th and 7th are ignored. done=1 after 5 pops.
- Halt event → kind=5, state=DONE_HALT. Event with halt+err in the same cycle → no record, state=ERROR. rst mid-drain → empty FIFO and counters at 0.
